// File: rtl/clk_cfg_pkg.sv
// Shared types and decode constants for the clock-config APB initiator.
package clk_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    SEL_SOC     = 2'd0,
    SEL_PER     = 2'd1,
    SEL_CLUSTER = 2'd2,
    SEL_STATUS  = 2'd3
  } sel_e;

  localparam int STATUS_LOCK_LSB = 0;
  localparam int STATUS_ERR_BIT  = 3;

  localparam int SEL_MSB = 5;
  localparam int SEL_LSB = 4;
  localparam int ADD_MSB = 3;
  localparam int ADD_LSB = 2;

  function automatic logic [2:0] sel_onehot(input sel_e sel);
    logic [2:0] oh;
    oh = 3'b000;
    case (sel)
      SEL_SOC:     oh = 3'b001;
      SEL_PER:     oh = 3'b010;
      SEL_CLUSTER: oh = 3'b100;
      default:     oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/clk_cfg_initiator_if.sv
// APB slave port plus the three four-phase cfg ports of the initiator.
// APB: an access completes in the one cycle where psel & penable & pready are all high;
// cfg: req rises, ack rises, req falls, ack falls, and add/data/wrn hold from req rise until ack falls.
interface clk_cfg_initiator_if #(
    parameter int APB_ADDR_WIDTH = 12
);
    logic [APB_ADDR_WIDTH-1:0] paddr_i;
    logic [31:0]               pwdata_i;
    logic                      pwrite_i;
    logic                      psel_i;
    logic                      penable_i;
    logic [31:0]               prdata_o;
    logic                      pready_o;
    logic                      pslverr_o;

    logic        soc_cfg_req_o;
    logic        soc_cfg_ack_i;
    logic [1:0]  soc_cfg_add_o;
    logic [31:0] soc_cfg_data_o;
    logic        soc_cfg_wrn_o;
    logic [31:0] soc_cfg_r_data_i;
    logic        soc_cfg_lock_i;

    logic        per_cfg_req_o;
    logic        per_cfg_ack_i;
    logic [1:0]  per_cfg_add_o;
    logic [31:0] per_cfg_data_o;
    logic        per_cfg_wrn_o;
    logic [31:0] per_cfg_r_data_i;
    logic        per_cfg_lock_i;

    logic        cluster_cfg_req_o;
    logic        cluster_cfg_ack_i;
    logic [1:0]  cluster_cfg_add_o;
    logic [31:0] cluster_cfg_data_o;
    logic        cluster_cfg_wrn_o;
    logic [31:0] cluster_cfg_r_data_i;
    logic        cluster_cfg_lock_i;

    // master: the initiator itself (drives the cfg handshakes)
    modport master (
        input  paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        output prdata_o, pready_o, pslverr_o,
        output soc_cfg_req_o, soc_cfg_add_o, soc_cfg_data_o, soc_cfg_wrn_o,
        input  soc_cfg_ack_i, soc_cfg_r_data_i, soc_cfg_lock_i,
        output per_cfg_req_o, per_cfg_add_o, per_cfg_data_o, per_cfg_wrn_o,
        input  per_cfg_ack_i, per_cfg_r_data_i, per_cfg_lock_i,
        output cluster_cfg_req_o, cluster_cfg_add_o, cluster_cfg_data_o, cluster_cfg_wrn_o,
        input  cluster_cfg_ack_i, cluster_cfg_r_data_i, cluster_cfg_lock_i
    );

    modport slave (
        output paddr_i, pwdata_i, pwrite_i, psel_i, penable_i,
        input  prdata_o, pready_o, pslverr_o,
        input  soc_cfg_req_o, soc_cfg_add_o, soc_cfg_data_o, soc_cfg_wrn_o,
        output soc_cfg_ack_i, soc_cfg_r_data_i, soc_cfg_lock_i,
        input  per_cfg_req_o, per_cfg_add_o, per_cfg_data_o, per_cfg_wrn_o,
        output per_cfg_ack_i, per_cfg_r_data_i, per_cfg_lock_i,
        input  cluster_cfg_req_o, cluster_cfg_add_o, cluster_cfg_data_o, cluster_cfg_wrn_o,
        output cluster_cfg_ack_i, cluster_cfg_r_data_i, cluster_cfg_lock_i
    );

endinterface

// File: rtl/clk_cfg_sync.sv
// Two-flop synchronizer for an asynchronous level input.
module clk_cfg_sync (
    input  logic ref_clk_i,
    input  logic rstn_glob_i,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
        if (!rstn_glob_i) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/clk_cfg_initiator.sv
// APB slave that forwards accesses over four-phase cfg handshakes to soc/per/cluster
// clock domains, with a local STATUS register and a handshake timeout.
module clk_cfg_initiator
    import clk_cfg_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int APB_ADDR_WIDTH = 12
) (
    input  logic                 ref_clk_i,
    input  logic                 rstn_glob_i,
    clk_cfg_initiator_if.master  bus,
    output state_e               dbg_state
);

    localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYCLES);

    state_e      state_q;
    sel_e        sel_q;
    logic [1:0]  add_q;
    logic [31:0] data_q;
    logic        wrn_q;
    logic [2:0]  req_q;
    logic [7:0]  cnt_q;
    logic        err_q;
    logic        tout_q;
    logic        abort_q;
    logic [31:0] resp_q;
    logic [2:0]  lock_sync;

    logic        access;
    sel_e        acc_sel;
    logic        ack_sel;
    logic [31:0] rdata_sel;
    logic        timeout_hit;
    logic [31:0] status_word;
    logic        unused_bits;

    clk_cfg_sync u_sync_soc (
        .ref_clk_i(ref_clk_i), .rstn_glob_i(rstn_glob_i),
        .d(bus.soc_cfg_lock_i), .q(lock_sync[0])
    );
    clk_cfg_sync u_sync_per (
        .ref_clk_i(ref_clk_i), .rstn_glob_i(rstn_glob_i),
        .d(bus.per_cfg_lock_i), .q(lock_sync[1])
    );
    clk_cfg_sync u_sync_cluster (
        .ref_clk_i(ref_clk_i), .rstn_glob_i(rstn_glob_i),
        .d(bus.cluster_cfg_lock_i), .q(lock_sync[2])
    );

    assign access      = bus.psel_i & bus.penable_i & ~bus.pready_o;
    assign acc_sel     = sel_e'(bus.paddr_i[SEL_MSB:SEL_LSB]);
    assign timeout_hit = (cnt_q == TIMEOUT_LIM);
    assign unused_bits = ^{bus.paddr_i[APB_ADDR_WIDTH-1:SEL_MSB+1], bus.paddr_i[ADD_LSB-1:0]};

    always_comb begin
        status_word = 32'd0;
        status_word[STATUS_LOCK_LSB +: 3] = lock_sync;
        status_word[STATUS_ERR_BIT]       = err_q;
    end

    always_comb begin
        ack_sel   = 1'b0;
        rdata_sel = 32'd0;
        case (sel_q)
            SEL_SOC: begin
                ack_sel   = bus.soc_cfg_ack_i;
                rdata_sel = bus.soc_cfg_r_data_i;
            end
            SEL_PER: begin
                ack_sel   = bus.per_cfg_ack_i;
                rdata_sel = bus.per_cfg_r_data_i;
            end
            SEL_CLUSTER: begin
                ack_sel   = bus.cluster_cfg_ack_i;
                rdata_sel = bus.cluster_cfg_r_data_i;
            end
            default: begin
                ack_sel   = 1'b0;
                rdata_sel = 32'd0;
            end
        endcase
    end

    always_ff @(posedge ref_clk_i or negedge rstn_glob_i) begin
        if (!rstn_glob_i) begin
            state_q <= ST_IDLE;
            sel_q   <= SEL_SOC;
            add_q   <= 2'd0;
            data_q  <= 32'd0;
            wrn_q   <= 1'b0;
            req_q   <= 3'b000;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
            abort_q <= 1'b0;
            resp_q  <= 32'd0;
        end else begin
            // A master dropping psel mid-handshake still lets the handshake finish; only the reply is lost.
            if ((state_q == ST_REQ || state_q == ST_RELEASE) && !bus.psel_i)
                abort_q <= 1'b1;

            case (state_q)
                ST_IDLE: begin
                    if (access) begin
                        abort_q <= 1'b0;
                        tout_q  <= 1'b0;
                        if (acc_sel == SEL_STATUS) begin
                            resp_q  <= bus.pwrite_i ? 32'd0 : status_word;
                            if (bus.pwrite_i && bus.pwdata_i[STATUS_ERR_BIT])
                                err_q <= 1'b0;
                            state_q <= ST_RESP;
                        end else begin
                            sel_q   <= acc_sel;
                            add_q   <= bus.paddr_i[ADD_MSB:ADD_LSB];
                            data_q  <= bus.pwdata_i;
                            wrn_q   <= bus.pwrite_i;
                            req_q   <= sel_onehot(acc_sel);
                            cnt_q   <= 8'd0;
                            state_q <= ST_REQ;
                        end
                    end
                end
                ST_REQ: begin
                    if (ack_sel) begin
                        resp_q  <= rdata_sel;
                        req_q   <= 3'b000;
                        cnt_q   <= 8'd0;
                        state_q <= ST_RELEASE;
                    end else if (timeout_hit) begin
                        req_q   <= 3'b000;
                        err_q   <= 1'b1;
                        tout_q  <= 1'b1;
                        resp_q  <= 32'd0;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                ST_RELEASE: begin
                    if (!ack_sel) begin
                        state_q <= ST_RESP;
                    end else if (timeout_hit) begin
                        err_q   <= 1'b1;
                        tout_q  <= 1'b1;
                        resp_q  <= 32'd0;
                        state_q <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.pready_o  = (state_q == ST_RESP) & ~abort_q;
    assign bus.prdata_o  = bus.pready_o ? resp_q : 32'd0;
    assign bus.pslverr_o = bus.pready_o & tout_q;

    assign bus.soc_cfg_req_o      = req_q[0];
    assign bus.per_cfg_req_o      = req_q[1];
    assign bus.cluster_cfg_req_o  = req_q[2];
    assign bus.soc_cfg_add_o      = add_q;
    assign bus.per_cfg_add_o      = add_q;
    assign bus.cluster_cfg_add_o  = add_q;
    assign bus.soc_cfg_data_o     = data_q;
    assign bus.per_cfg_data_o     = data_q;
    assign bus.cluster_cfg_data_o = data_q;
    assign bus.soc_cfg_wrn_o      = wrn_q;
    assign bus.per_cfg_wrn_o      = wrn_q;
    assign bus.cluster_cfg_wrn_o  = wrn_q;

    assign dbg_state = state_q;

endmodule

// File: tb/tb_clk_cfg_initiator.sv
// Directed bench for clk_cfg_initiator with combinational domain responders and an APB scoreboard.
module tb_clk_cfg_initiator;
    import clk_cfg_pkg::*;

    localparam int AW = 12;
    localparam int TO = 255;
    localparam int WAIT_MAX = 400;

    // clock / reset
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    clk_cfg_initiator_if #(.APB_ADDR_WIDTH(AW)) bus ();
    state_e dbg_state;

    clk_cfg_initiator #(.TIMEOUT_CYCLES(TO), .APB_ADDR_WIDTH(AW)) dut (
        .ref_clk_i  (clk),
        .rstn_glob_i(rstn),
        .bus        (bus.master),
        .dbg_state  (dbg_state)
    );

    int checks = 0;
    int errors = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // domain models: combinational ack, register file read, write on ack
    logic soc_ack_en = 1'b1, per_ack_en = 1'b1, cl_ack_en = 1'b1;
    logic [31:0] soc_regs[4];
    logic [31:0] per_regs[4];
    logic [31:0] cl_regs[4];

    assign bus.soc_cfg_ack_i        = bus.soc_cfg_req_o & soc_ack_en;
    assign bus.per_cfg_ack_i        = bus.per_cfg_req_o & per_ack_en;
    assign bus.cluster_cfg_ack_i    = bus.cluster_cfg_req_o & cl_ack_en;
    assign bus.soc_cfg_r_data_i     = bus.soc_cfg_wrn_o ? 32'd0 : soc_regs[bus.soc_cfg_add_o];
    assign bus.per_cfg_r_data_i     = bus.per_cfg_wrn_o ? 32'd0 : per_regs[bus.per_cfg_add_o];
    assign bus.cluster_cfg_r_data_i = bus.cluster_cfg_wrn_o ? 32'd0 : cl_regs[bus.cluster_cfg_add_o];

    always @(posedge clk) begin
        if (!rstn) begin
            soc_regs[0] <= 32'h0001_0001; soc_regs[1] <= 32'h0000_0011;
            soc_regs[2] <= 32'h0000_0022; soc_regs[3] <= 32'hfffe_fffc;
            for (int i = 0; i < 4; i++) begin
                per_regs[i] <= 32'd0;
                cl_regs[i]  <= 32'hcafe_0000 + 32'(i);
            end
        end else begin
            if (bus.soc_cfg_req_o && bus.soc_cfg_ack_i && bus.soc_cfg_wrn_o)
                soc_regs[bus.soc_cfg_add_o] <= bus.soc_cfg_data_o;
            if (bus.per_cfg_req_o && bus.per_cfg_ack_i && bus.per_cfg_wrn_o)
                per_regs[bus.per_cfg_add_o] <= bus.per_cfg_data_o;
            if (bus.cluster_cfg_req_o && bus.cluster_cfg_ack_i && bus.cluster_cfg_wrn_o)
                cl_regs[bus.cluster_cfg_add_o] <= bus.cluster_cfg_data_o;
        end
    end

    // req watcher: cumulative high-cycle counts and last seen request fields
    int soc_req_cyc = 0, per_req_cyc = 0, cl_req_cyc = 0;
    logic [1:0]  soc_add_seen;
    logic        soc_wrn_seen;
    logic [31:0] per_data_seen;
    logic        per_wrn_seen;

    always @(negedge clk) begin
        if (bus.soc_cfg_req_o) begin
            soc_req_cyc++;
            soc_add_seen = bus.soc_cfg_add_o;
            soc_wrn_seen = bus.soc_cfg_wrn_o;
        end
        if (bus.per_cfg_req_o) begin
            per_req_cyc++;
            per_data_seen = bus.per_cfg_data_o;
            per_wrn_seen  = bus.per_cfg_wrn_o;
        end
        if (bus.cluster_cfg_req_o) cl_req_cyc++;
    end

    // scoreboard monitor
    always @(negedge clk) begin
        logic [32:0] e;
        if (rstn && bus.pready_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pready actual=1 required=0");
            end else begin
                e = exp_q.pop_front();
                check("prdata", bus.prdata_o, e[31:0]);
                check("pslverr", 32'(bus.pslverr_o), 32'(e[32]));
            end
        end
    end

    // APB driver: one full transfer, expected reply pushed up front
    task automatic apb_xfer(input logic [AW-1:0] addr, input logic [31:0] wdata, input logic wr,
                            input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
        int  n;
        logic got;
        exp_q.push_back({exp_err, exp_data});
        @(posedge clk); #1;
        bus.paddr_i   = addr;
        bus.pwdata_i  = wdata;
        bus.pwrite_i  = wr;
        bus.psel_i    = 1'b1;
        bus.penable_i = 1'b0;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        n = 0;
        got = 1'b0;
        while (!got && n < WAIT_MAX) begin
            @(posedge clk); #1;
            n++;
            if (bus.pready_o) got = 1'b1;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL pready_timeout addr=0x%03h actual=none required=pready", addr);
            void'(exp_q.pop_back());
        end else begin
            check("latency", 32'(n), 32'(exp_lat));
        end
        @(posedge clk); #1;
        bus.psel_i    = 1'b0;
        bus.penable_i = 1'b0;
    endtask

    initial begin
        int s0, s1, s2;
        bus.paddr_i = '0; bus.pwdata_i = '0; bus.pwrite_i = 1'b0;
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        bus.soc_cfg_lock_i = 1'b0; bus.per_cfg_lock_i = 1'b0; bus.cluster_cfg_lock_i = 1'b0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req", {29'd0, bus.cluster_cfg_req_o, bus.per_cfg_req_o, bus.soc_cfg_req_o}, 32'd0);
        check("rst_pready", {30'd0, bus.pready_o, bus.pslverr_o}, 32'd0);
        check("rst_prdata", bus.prdata_o, 32'd0);
        check("rst_cfg_fields", {bus.soc_cfg_data_o[28:0], bus.soc_cfg_add_o, bus.soc_cfg_wrn_o}, 32'd0);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        rstn = 1'b1;
        repeat (2) @(posedge clk);

        // 1: soc read of register 3
        apb_xfer(12'h00C, 32'd0, 1'b0, 32'hfffe_fffc, 1'b0, 3);
        check("s1_soc_add", 32'(soc_add_seen), 32'd3);
        check("s1_soc_wrn", 32'(soc_wrn_seen), 32'd0);

        // 2: per write, only per req pulses for one cycle
        s0 = soc_req_cyc; s1 = per_req_cyc; s2 = cl_req_cyc;
        apb_xfer(12'h014, 32'h1234_5678, 1'b1, 32'd0, 1'b0, 3);
        check("s2_per_req_cycles", 32'(per_req_cyc - s1), 32'd1);
        check("s2_other_req_cycles", 32'((soc_req_cyc - s0) + (cl_req_cyc - s2)), 32'd0);
        check("s2_per_data", per_data_seen, 32'h1234_5678);
        check("s2_per_wrn", 32'(per_wrn_seen), 32'd1);
        apb_xfer(12'h014, 32'd0, 1'b0, 32'h1234_5678, 1'b0, 3);

        // 3: lock sync into STATUS
        @(posedge clk); #1;
        bus.soc_cfg_lock_i = 1'b1; bus.per_cfg_lock_i = 1'b0; bus.cluster_cfg_lock_i = 1'b1;
        repeat (3) @(posedge clk);
        apb_xfer(12'h030, 32'd0, 1'b0, 32'h0000_0005, 1'b0, 1);

        // 4: cluster never acks -> timeout, sticky error, then clear
        cl_ack_en = 1'b0;
        apb_xfer(12'h020, 32'd0, 1'b0, 32'd0, 1'b1, TO + 2);
        cl_ack_en = 1'b1;
        apb_xfer(12'h030, 32'd0, 1'b0, 32'h0000_000D, 1'b0, 1);
        apb_xfer(12'h030, 32'h0000_0008, 1'b1, 32'd0, 1'b0, 1);
        apb_xfer(12'h030, 32'd0, 1'b0, 32'h0000_0005, 1'b0, 1);

        // 5: reset while soc req is high
        @(posedge clk); #1;
        bus.paddr_i = 12'h000; bus.pwrite_i = 1'b0; bus.psel_i = 1'b1; bus.penable_i = 1'b0;
        @(posedge clk); #1;
        bus.penable_i = 1'b1;
        @(posedge clk); #1;
        check("s5_req_before_rst", 32'(bus.soc_cfg_req_o), 32'd1);
        rstn = 1'b0;
        #1;
        check("s5_req_in_rst", 32'(bus.soc_cfg_req_o), 32'd0);
        check("s5_state_in_rst", 32'(dbg_state), 32'(ST_IDLE));
        bus.psel_i = 1'b0; bus.penable_i = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        apb_xfer(12'h000, 32'd0, 1'b0, 32'h0001_0001, 1'b0, 3);

        repeat (4) @(posedge clk);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/clk_cfg_initiator.md
CLK_CFG_INITIATOR -- requirements
Module: clk_cfg_initiator

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles spent waiting on a cfg ack edge.
REQ-002 The block SHALL have parameter APB_ADDR_WIDTH, default 12, giving the APB address width.
REQ-003 ref_clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 rstn_glob_i  in  1  reset, asynchronous, active-low.
REQ-005 paddr_i  in  APB_ADDR_WIDTH  APB address.
REQ-006 pwdata_i  in  32  APB write data.
REQ-007 pwrite_i  in  1  APB direction, 1 = write.
REQ-008 psel_i  in  1  APB select.
REQ-009 penable_i  in  1  APB enable.
REQ-010 prdata_o  out  32  APB read data.
REQ-011 pready_o  out  1  APB ready.
REQ-012 pslverr_o  out  1  APB error.
REQ-013 soc_cfg_req_o  out  1  four-phase request to the soc clock domain.
REQ-014 soc_cfg_ack_i  in  1  four-phase acknowledge.
REQ-015 soc_cfg_add_o  out  2  cfg register index.
REQ-016 soc_cfg_data_o  out  32  cfg write data.
REQ-017 soc_cfg_wrn_o  out  1  1 = write, 0 = read.
REQ-018 soc_cfg_r_data_i  in  32  cfg read data.
REQ-019 soc_cfg_lock_i  in  1  asynchronous lock indication.
REQ-020 The block SHALL provide per_cfg_* and cluster_cfg_* port sets identical to REQ-013 to REQ-019.

Function
REQ-021 Address decode SHALL use paddr_i[5:4] to select the target: 00 soc, 01 per, 10 cluster, 11 local STATUS. paddr_i[3:2] SHALL drive cfg_add_o.
REQ-022 The FSM states SHALL be IDLE, REQ, RELEASE and RESP.
REQ-023 IDLE SHALL transition to REQ on psel_i & penable_i & ~pready_o for a domain target. For a STATUS target it SHALL transition directly to RESP.
REQ-024 On entry to REQ, add, data and wrn SHALL be latched from APB, and only the selected domain's req_o SHALL be asserted. All other domains' req_o SHALL remain 0.
REQ-025 In REQ, ack_i=1 SHALL capture r_data_i into the response register, deassert req_o and enter RELEASE.
REQ-026 In RELEASE, ack_i=0 SHALL enter RESP.
REQ-027 RESP SHALL drive pready_o=1 for exactly one cycle with the captured prdata_o, then return to IDLE.
REQ-028 Latency with a combinational responder: first access-phase cycle T, req_o=1 at T+1, req_o=0 at T+2, pready_o=1 at T+3. For STATUS, pready_o=1 at T+1.
REQ-029 add, data and wrn outputs SHALL hold stable from req_o rise until ack_i falls.
REQ-030 An 8-bit timeout counter SHALL clear on entry to REQ and to RELEASE, and increment every cycle in those states.
REQ-031 When the timeout counter reaches TIMEOUT_CYCLES, the FSM SHALL force req_o=0, set the sticky error bit, enter RESP with pslverr_o=1 and prdata_o=0.
REQ-032 STATUS read SHALL return bits[2:0] = synchronized {cluster,per,soc} lock, bit[3] = sticky timeout error, and all other bits 0.
REQ-033 A STATUS write with pwdata_i[3]=1 SHALL clear the error bit. All other written bits SHALL be ignored.
REQ-034 Each lock input SHALL pass through a 2-flop synchronizer, giving 2-cycle latency to STATUS.
REQ-035 If psel_i drops mid-transfer, which is an APB protocol violation, the block SHALL complete the cfg handshake and discard the response.
REQ-036 A new access SHALL only be accepted in IDLE. No pipelining of accesses SHALL occur.
REQ-037 pslverr_o SHALL be 0 except in RESP after a timeout.

Reset
REQ-038 On rstn_glob_i=0, FSM=IDLE and all req_o, pready_o, pslverr_o, prdata_o, cfg_add_o, cfg_data_o, cfg_wrn_o, counter, error bit and synchronizers SHALL clear to 0 immediately.
REQ-039 Reset asserted mid-REQ SHALL drop req_o asynchronously. After release, the block SHALL wait in IDLE for a new access.

Structure
REQ-040 The package clk_cfg_pkg SHALL hold the FSM state enum, the domain-select enum (SOC, PER, CLUSTER, STATUS), STATUS bit positions and the decode bit ranges.
REQ-041 The sub-module clk_cfg_sync SHALL implement the 2-flop synchronizer, one instance per lock input.

Verification
REQ-042 Scenario 1: read paddr 0x00C against the clk_gen model -> soc_cfg_add_o=3, soc_cfg_wrn_o=0, prdata_o=0xfffefffc, pready_o at T+3.
REQ-043 Scenario 2: write paddr 0x014, pwdata 0x12345678 -> per_cfg_req_o high 1 cycle, per_cfg_data_o=0x12345678, per_cfg_wrn_o=1, soc and cluster req stay 0.
REQ-044 Scenario 3: locks {cluster,per,soc}=3'b101, then after 3 cycles read paddr 0x030 -> prdata_o=0x00000005, pready_o at T+1.
REQ-045 Scenario 4: cluster_cfg_ack_i tied 0, read paddr 0x020 -> pslverr_o=1, prdata_o=0, STATUS bit3=1. A subsequent STATUS write of 0x8 -> bit3=0.
REQ-046 Scenario 5: reset pulsed while soc_cfg_req_o=1 -> req_o=0 within the same cycle, FSM IDLE. The next read of paddr 0x000 returns 0x00010001.
